fu_divsqrt_otfc: RTL and testbench

FU_DIVSQRT_OTFC -- requirements
Module: fu_divsqrt_otfc

---
 rtl/fu_divsqrt_pkg.sv | 14 +
 rtl/fu_divsqrt_otfc_sel.sv | 34 +++
 rtl/fu_divsqrt_otfc.sv | 91 +++++++++
 tb/tb_fu_divsqrt_otfc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fu_divsqrt_pkg.sv
// Shared definitions for the divide/sqrt functional unit: controller states and
// the legal range of signed radix-4 quotient digits.
package fu_divsqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic signed [2:0] DIG_MAX = 3'sd2;
    localparam logic signed [2:0] DIG_MIN = -3'sd2;

endpackage

// File: rtl/fu_divsqrt_otfc_sel.sv
// Per-digit selection for on-the-fly conversion: picks the source register and the
// two bits appended to Q and QM for one signed radix-4 digit.
module fu_divsqrt_otfc_sel
    import fu_divsqrt_pkg::*;
(
    input  logic [0:2] dig,
    output logic [1:0] q_low,
    output logic       q_from_qm,
    output logic [1:0] qm_low,
    output logic       qm_from_qm,
    output logic       illegal
);

    logic signed [2:0] d;

    assign d = dig;

    // For a legal digit, 4+d (d<0) and d (d>=0) share the same low two bits,
    // as do 3+d and d-1, so only the source register depends on the sign.
    always_comb begin
        illegal    = (d > DIG_MAX) || (d < DIG_MIN);
        q_low      = 2'd0;
        q_from_qm  = 1'b0;
        qm_low     = 2'd3;
        qm_from_qm = 1'b1;
        if (!illegal) begin
            q_low      = d[1:0];
            qm_low     = d[1:0] - 2'd1;
            q_from_qm  = (d < 0);
            qm_from_qm = (d <= 0);
        end
    end

endmodule

// File: rtl/fu_divsqrt_otfc.sv
// On-the-fly converter: accumulates signed radix-4 quotient digits into Q and
// Q-1ulp (QM) using concatenation only, with no carry propagation.
module fu_divsqrt_otfc
    import fu_divsqrt_pkg::*;
#(
    parameter int QW = 56,
    parameter int ND = QW / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dig_val,
    input  logic [0:2]    dig,
    input  logic          last,
    output logic          busy,
    output logic          q_val,
    output logic [0:QW-1] q_out,
    output logic [0:QW-1] qm_out,
    output logic          err
);

    localparam int CW = $clog2(ND + 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    q_low;
    logic [1:0]    qm_low;
    logic          q_from_qm;
    logic          qm_from_qm;
    logic          illegal;
    logic [0:QW-1] q_src;
    logic [0:QW-1] qm_src;
    logic [0:QW-1] q_next;
    logic [0:QW-1] qm_next;

    fu_divsqrt_otfc_sel u_sel (
        .dig        (dig),
        .q_low      (q_low),
        .q_from_qm  (q_from_qm),
        .qm_low     (qm_low),
        .qm_from_qm (qm_from_qm),
        .illegal    (illegal)
    );

    // Bits 0 and 1 (the MSBs) fall off the top: arithmetic is modulo 2^QW.
    assign q_src   = q_from_qm  ? qm_out : q_out;
    assign qm_src  = qm_from_qm ? qm_out : q_out;
    assign q_next  = {q_src[2:QW-1], q_low};
    assign qm_next = {qm_src[2:QW-1], qm_low};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            q_out  <= '0;
            qm_out <= '0;
            busy   <= 1'b0;
            q_val  <= 1'b0;
            err    <= 1'b0;
        end else begin
            q_val <= 1'b0;
            if (start) begin
                state  <= ST_ACC;
                count  <= '0;
                q_out  <= '0;
                qm_out <= '1;
                busy   <= 1'b1;
                err    <= 1'b0;
            end else begin
                case (state)
                    ST_ACC: begin
                        if (dig_val) begin
                            q_out  <= q_next;
                            qm_out <= qm_next;
                            count  <= count + CW'(1);
                            if (illegal) err <= 1'b1;
                            if (last || count == CW'(ND - 1)) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                q_val <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fu_divsqrt_otfc.sv
// Bench for the on-the-fly converter: directed cases plus random digit streams,
// compared against the plain integer value sum(d_i * 4^(n-1-i)) mod 2^QW.
module tb_fu_divsqrt_otfc;

    localparam int QW = 8;
    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dig_val;
    logic [0:2]    dig;
    logic          last;
    logic          busy;
    logic          q_val;
    logic [0:QW-1] q_out;
    logic [0:QW-1] qm_out;
    logic          err;

    int checks = 0;
    int errors = 0;

    fu_divsqrt_otfc #(.QW(QW), .ND(ND)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dig_val (dig_val),
        .dig     (dig),
        .last    (last),
        .busy    (busy),
        .q_val   (q_val),
        .q_out   (q_out),
        .qm_out  (qm_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full operation: start, n digits (optional idle gaps), then the result checks.
    task automatic run_op(input int n, input int digs[4], input bit force_last, input bit gaps);
        int             qv;
        bit             e;
        int             d;
        logic [QW-1:0]  eq;
        logic [QW-1:0]  eqm;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_acc", busy, 1);
        check("q_init", q_out, 0);
        check("qm_init", qm_out, 8'hFF);
        check("err_clr", err, 0);
        qv = 0;
        e  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                dig_val = 1'b0;
                dig     = 3'($urandom);
                last    = 1'($urandom);
                tick();
                check("gap_noqv", q_val, 0);
                check("gap_busy", busy, 1);
            end
            dig_val = 1'b1;
            dig     = 3'(digs[i]);
            last    = (i == n - 1) && (force_last || n < ND);
            tick();
            dig_val = 1'b0;
            last    = 1'b0;
            d = digs[i];
            if (d >= -2 && d <= 2) begin
                qv = qv * 4 + d;
            end else begin
                qv = qv * 4;
                e  = 1'b1;
            end
            if (i < n - 1) check("mid_noqv", q_val, 0);
        end
        eq  = qv[QW-1:0];
        eqm = eq - 1'b1;
        check("qval", q_val, 1);
        check("q_out", q_out, eq);
        check("qm_out", qm_out, eqm);
        check("err", err, e);
        check("busy_done", busy, 0);
        tick();
        check("qval_pulse", q_val, 0);
        check("q_hold", q_out, eq);
        check("qm_hold", qm_out, eqm);
    endtask

    initial begin
        int digs[4];
        int sel;
        rst     = 1'b1;
        start   = 1'b0;
        dig_val = 1'b0;
        dig     = 3'd0;
        last    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_q", q_out, 0);
        check("rst_qm", qm_out, 0);
        check("rst_busy", busy, 0);
        check("rst_qval", q_val, 0);
        check("rst_err", err, 0);

        // dig_val while idle is ignored
        dig_val = 1'b1;
        dig     = 3'd1;
        last    = 1'b1;
        tick();
        dig_val = 1'b0;
        last    = 1'b0;
        check("idle_q", q_out, 0);
        check("idle_qval", q_val, 0);

        run_op(4, '{1, 2, -1, 0}, 1'b1, 1'b0);
        run_op(4, '{-2, 1, 0, 0}, 1'b0, 1'b0);
        run_op(2, '{2, 2, 0, 0}, 1'b1, 1'b0);
        run_op(4, '{1, 3, 1, 0}, 1'b1, 1'b0);
        run_op(4, '{-3, -4, 2, -1}, 1'b0, 1'b0);

        // Abort mid-operation by a fresh start; only the second operation reports.
        start = 1'b1;
        tick();
        start   = 1'b0;
        dig_val = 1'b1;
        dig     = 3'd1;
        tick();
        tick();
        dig_val = 1'b0;
        check("abort_noqv", q_val, 0);
        run_op(4, '{0, 0, 0, 1}, 1'b1, 1'b0);

        // start wins over a final digit in the same cycle
        start = 1'b1;
        tick();
        dig_val = 1'b1;
        dig     = 3'd2;
        last    = 1'b1;
        tick();
        start   = 1'b0;
        dig_val = 1'b0;
        last    = 1'b0;
        check("prio_noqv", q_val, 0);
        check("prio_busy", busy, 1);
        check("prio_q", q_out, 0);
        check("prio_qm", qm_out, 8'hFF);

        // Reset mid-accumulation abandons the operation
        start = 1'b1;
        tick();
        start   = 1'b0;
        dig_val = 1'b1;
        dig     = 3'd1;
        tick();
        tick();
        dig_val = 1'b0;
        rst     = 1'b1;
        start   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("mrst_q", q_out, 0);
        check("mrst_qm", qm_out, 0);
        check("mrst_busy", busy, 0);
        check("mrst_qval", q_val, 0);
        check("mrst_err", err, 0);
        for (int i = 0; i < 4; i++) begin
            dig_val = 1'b1;
            dig     = 3'(-1);
            last    = (i == 3);
            tick();
            check("mrst_ign_qval", q_val, 0);
            check("mrst_ign_q", q_out, 0);
        end
        dig_val = 1'b0;
        last    = 1'b0;

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) < 8) begin
                    digs[i] = int'($urandom_range(0, 4)) - 2;
                end else begin
                    sel = int'($urandom_range(0, 2));
                    digs[i] = (sel == 0) ? 3 : (sel == 1) ? -3 : -4;
                end
            end
            run_op(int'($urandom_range(1, ND)), digs, 1'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
